regfile_param: RTL and testbench

Parametrised general-purpose register file, the successor to the fixed 32x32 two-read-port file used by the single-cycle RV32I core.
- Generic in data width, depth (via address width) and read-port count.
- Optional hardwired-zero register 0.
- Optional write-to-read bypass.
- Built-in pending-write scoreboard, so the multi-cycle and pipelined cores can detect RAW hazards without an external tracker.

---
 rtl/regfile_param.sv | 82 ++++++++
 tb/tb_regfile_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: combinational reads with optional write bypass and zero register,
// one-cycle write latency, plus a pending-write scoreboard that raises per-port busy for RAW stalls.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rs_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rs_data_o,
    output logic [NUM_RD-1:0]          rs_busy_o,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [DATA_W-1:0]          rd_data_i,
    input  logic                       rd_wren_i,
    input  logic                       iss_valid_i,
    input  logic [ADDR_W-1:0]          iss_addr_i,
    output logic [2**ADDR_W-1:0]       pend_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              wr_zero;
    logic              wr_en;
    logic              fwd_en;

    assign wr_zero = (ZERO_REG != 0) && (rd_addr_i == '0);
    assign wr_en   = rd_wren_i && !wr_zero;
    // Forwarding is held off during reset so the read ports show the cleared state.
    assign fwd_en  = (BYPASS != 0) && wr_en && nrst_i;

    // Issue is applied after retire so a same-address issue supersedes the retiring write.
    always_comb begin
        pend_nxt = pend;
        if (rd_wren_i) begin
            pend_nxt[rd_addr_i] = 1'b0;
        end
        if (iss_valid_i) begin
            pend_nxt[iss_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pend <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                regs[n] <= '0;
            end
        end else begin
            pend <= pend_nxt;
            if (wr_en) begin
                regs[rd_addr_i] <= rd_data_i;
            end
        end
    end

    assign pend_o = pend;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = rs_addr_i[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = fwd_en && (rd_addr_i == addr);

        assign rs_data_o[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                               hit     ? rd_data_i : regs[addr];
        // Forwarded data satisfies the hazard, so a bypass hit is never busy.
        assign rs_busy_o[k] = !is_zero && !hit && pend[addr];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default, no-bypass and 64-bit/3-port instances checked against table and scoreboard.
module tb_regfile_param;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  rs_addr   = '0;
    logic [63:0] rs_data;
    logic [63:0] nb_rs_data;
    logic [1:0]  rs_busy;
    logic [1:0]  nb_rs_busy;
    logic [4:0]  rd_addr   = '0;
    logic [31:0] rd_data   = '0;
    logic        rd_wren   = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr  = '0;
    logic [31:0] pend;
    logic [31:0] nb_pend;

    logic [11:0]  w_rs_addr   = '0;
    logic [191:0] w_rs_data;
    logic [2:0]   w_rs_busy;
    logic [3:0]   w_rd_addr   = '0;
    logic [63:0]  w_rd_data   = '0;
    logic         w_rd_wren   = 1'b0;
    logic         w_iss_valid = 1'b0;
    logic [3:0]   w_iss_addr  = '0;
    logic [15:0]  w_pend;

    regfile_param u_dut (
        .clk_i(clk), .nrst_i(nrst), .rs_addr_i(rs_addr), .rs_data_o(rs_data),
        .rs_busy_o(rs_busy), .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_wren_i(rd_wren),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .pend_o(pend)
    );

    regfile_param #(.BYPASS(0)) u_nobyp (
        .clk_i(clk), .nrst_i(nrst), .rs_addr_i(rs_addr), .rs_data_o(nb_rs_data),
        .rs_busy_o(nb_rs_busy), .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_wren_i(rd_wren),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .pend_o(nb_pend)
    );

    regfile_param #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) u_wide (
        .clk_i(clk), .nrst_i(nrst), .rs_addr_i(w_rs_addr), .rs_data_o(w_rs_data),
        .rs_busy_o(w_rs_busy), .rd_addr_i(w_rd_addr), .rd_data_i(w_rd_data), .rd_wren_i(w_rd_wren),
        .iss_valid_i(w_iss_valid), .iss_addr_i(w_iss_addr), .pend_o(w_pend)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    typedef struct {
        logic [4:0]  a0, a1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] d0, d1;
        logic [1:0]  busy;
        logic [31:0] nd0, nd1;
        logic [1:0]  nbusy;
        logic [31:0] pnd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string name, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [63:0] act);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got %h with nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, act, e.val);
            end
        end
    endtask

    function automatic vec_t mk(input logic [4:0] a0, input logic [4:0] a1, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic iv,
                                input logic [4:0] ia, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] busy, input logic [31:0] nd0, input logic [31:0] nd1,
                                input logic [1:0] nbusy, input logic [31:0] pnd);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.nd0 = nd0; v.nd1 = nd1; v.nbusy = nbusy; v.pnd = pnd;
        return v;
    endfunction

    function automatic logic [63:0] wide_exp(input int a);
        return (a == 0) ? 64'h0 : 64'(a) * 64'h0101010101010101;
    endfunction

    task automatic idle();
        rd_wren = 1'b0; rd_addr = '0; rd_data = '0; iss_valid = 1'b0; iss_addr = '0;
    endtask

    initial begin
        //        a0    a1    we  wa    wd             iv  ia    d0             d1             busy   nd0            nd1            nbusy  pend
        vecs.push_back(mk(5'd5, 5'd0, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h00000000, 32'h0, 2'b00, 32'h00000000, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h00000000, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd5, 5'd0, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h00000000, 32'h0, 2'b00, 32'h00000000, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd0, 5'd5, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h00000000, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0));
        vecs.push_back(mk(5'd7, 5'd3, 1, 5'd7, 32'h0BADF00D, 1, 5'd7, 32'h0BADF00D, 32'h0, 2'b00, 32'h00000000, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd7, 5'd7, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h0BADF00D, 32'h0BADF00D, 2'b11, 32'h0BADF00D, 32'h0BADF00D, 2'b11, 32'h80));
        vecs.push_back(mk(5'd3, 5'd7, 1, 5'd7, 32'h12345678, 0, 5'd0, 32'h00000000, 32'h12345678, 2'b00, 32'h0, 32'h0BADF00D, 2'b10, 32'h80));
        vecs.push_back(mk(5'd7, 5'd3, 0, 5'd0, 32'h00000000, 1, 5'd3, 32'h12345678, 32'h0, 2'b00, 32'h12345678, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd3, 5'd7, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h00000000, 32'h12345678, 2'b01, 32'h0, 32'h12345678, 2'b01, 32'h8));
        vecs.push_back(mk(5'd3, 5'd3, 0, 5'd0, 32'h00000000, 1, 5'd3, 32'h00000000, 32'h0, 2'b11, 32'h00000000, 32'h0, 2'b11, 32'h8));
        vecs.push_back(mk(5'd3, 5'd2, 1, 5'd3, 32'h33333333, 0, 5'd0, 32'h33333333, 32'h0, 2'b00, 32'h00000000, 32'h0, 2'b01, 32'h8));
        vecs.push_back(mk(5'd3, 5'd2, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h33333333, 32'h0, 2'b00, 32'h33333333, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd3, 5'd9, 1, 5'd3, 32'h44444444, 1, 5'd3, 32'h44444444, 32'h0, 2'b00, 32'h33333333, 32'h0, 2'b00, 32'h0));
        vecs.push_back(mk(5'd3, 5'd9, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h44444444, 32'h0, 2'b01, 32'h44444444, 32'h0, 2'b01, 32'h8));
        vecs.push_back(mk(5'd3, 5'd9, 1, 5'd3, 32'h55555555, 1, 5'd9, 32'h55555555, 32'h0, 2'b00, 32'h44444444, 32'h0, 2'b01, 32'h8));
        vecs.push_back(mk(5'd3, 5'd9, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h55555555, 32'h0, 2'b10, 32'h55555555, 32'h0, 2'b10, 32'h200));
        vecs.push_back(mk(5'd4, 5'd9, 1, 5'd4, 32'h00004444, 0, 5'd0, 32'h00004444, 32'h0, 2'b10, 32'h00000000, 32'h0, 2'b10, 32'h200));
        vecs.push_back(mk(5'd4, 5'd9, 0, 5'd0, 32'h00000000, 0, 5'd0, 32'h00004444, 32'h0, 2'b10, 32'h00004444, 32'h0, 2'b10, 32'h200));

        // Held in reset: everything reads zero.
        rs_addr = {5'd0, 5'd5};
        #2;
        expect_val("rst d0", 64'h0);
        expect_val("rst pend", 64'h0);
        expect_val("rst busy", 64'h0);
        check_next(64'(rs_data[31:0]));
        check_next(64'(pend));
        check_next(64'(rs_busy));
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rs_addr   = {vecs[i].a1, vecs[i].a0};
            rd_wren   = vecs[i].we;
            rd_addr   = vecs[i].wa;
            rd_data   = vecs[i].wd;
            iss_valid = vecs[i].iv;
            iss_addr  = vecs[i].ia;
            expect_val($sformatf("v%0d d0", i), 64'(vecs[i].d0));
            expect_val($sformatf("v%0d d1", i), 64'(vecs[i].d1));
            expect_val($sformatf("v%0d busy", i), 64'(vecs[i].busy));
            expect_val($sformatf("v%0d pend", i), 64'(vecs[i].pnd));
            expect_val($sformatf("v%0d nobyp d0", i), 64'(vecs[i].nd0));
            expect_val($sformatf("v%0d nobyp d1", i), 64'(vecs[i].nd1));
            expect_val($sformatf("v%0d nobyp busy", i), 64'(vecs[i].nbusy));
            expect_val($sformatf("v%0d nobyp pend", i), 64'(vecs[i].pnd));
            #1;
            check_next(64'(rs_data[31:0]));
            check_next(64'(rs_data[63:32]));
            check_next(64'(rs_busy));
            check_next(64'(pend));
            check_next(64'(nb_rs_data[31:0]));
            check_next(64'(nb_rs_data[63:32]));
            check_next(64'(nb_rs_busy));
            check_next(64'(nb_pend));
        end

        // Asynchronous reset between edges while x9 holds data and is pending.
        @(negedge clk);
        rd_wren = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5A5A5; iss_valid = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        idle();
        rs_addr = {5'd5, 5'd9};
        expect_val("pre-rst x9", 64'hA5A5A5A5);
        expect_val("pre-rst pend", 64'h200);
        expect_val("pre-rst busy", 64'h1);
        #1;
        check_next(64'(rs_data[31:0]));
        check_next(64'(pend));
        check_next(64'(rs_busy));
        #1;
        nrst = 1'b0;
        expect_val("mid-rst x9", 64'h0);
        expect_val("mid-rst x5", 64'h0);
        expect_val("mid-rst pend", 64'h0);
        expect_val("mid-rst busy", 64'h0);
        expect_val("mid-rst nobyp pend", 64'h0);
        #1;
        check_next(64'(rs_data[31:0]));
        check_next(64'(rs_data[63:32]));
        check_next(64'(pend));
        check_next(64'(rs_busy));
        check_next(64'(nb_pend));
        rd_wren = 1'b1; rd_addr = 5'd9; rd_data = 32'hFFFF0000;
        expect_val("rst write fwd", 64'h0);
        #1;
        check_next(64'(rs_data[31:0]));
        @(negedge clk);
        idle();
        nrst = 1'b1;
        @(negedge clk);
        expect_val("post-rst x9", 64'h0);
        expect_val("post-rst pend", 64'h0);
        #1;
        check_next(64'(rs_data[31:0]));
        check_next(64'(pend));

        // 64-bit, 16-entry, 3-port instance.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            w_rd_wren = 1'b1;
            w_rd_addr = 4'(i);
            w_rd_data = 64'(i) * 64'h0101010101010101;
        end
        @(negedge clk);
        w_rd_wren = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            w_rs_addr = {4'((j + 10) % 16), 4'((j + 5) % 16), 4'(j)};
            expect_val($sformatf("wide p0 x%0d", j), wide_exp(j));
            expect_val($sformatf("wide p1 x%0d", (j + 5) % 16), wide_exp((j + 5) % 16));
            expect_val($sformatf("wide p2 x%0d", (j + 10) % 16), wide_exp((j + 10) % 16));
            #1;
            check_next(w_rs_data[63:0]);
            check_next(w_rs_data[127:64]);
            check_next(w_rs_data[191:128]);
        end
        expect_val("wide busy", 64'h0);
        expect_val("wide pend", 64'h0);
        check_next(64'(w_rs_busy));
        check_next(64'(w_pend));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
